// File: rtl/dec_seq_pkg.sv
// rtl/dec_seq_pkg.sv - mode and state encodings for the sequencing decoder
package dec_seq_pkg;

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HOLD  = 2'b01,
    ST_PULSE = 2'b10,
    ST_SCAN  = 2'b11
  } state_t;

endpackage

// File: rtl/dec_onehot.sv
// rtl/dec_onehot.sv - combinational SEL_W-to-2^SEL_W one-hot decoder with enable
module dec_onehot #(
  parameter int SEL_W = 3
) (
  input  logic                    en,
  input  logic [SEL_W-1:0]        sel,
  output logic [(1<<SEL_W)-1:0]   out
);

  always_comb begin
    out = '0;
    if (en) out[sel] = 1'b1;
  end

endmodule

// File: rtl/dec_seq.sv
// rtl/dec_seq.sv - registered one-hot decoder with level, pulse and auto-scan modes
module dec_seq
  import dec_seq_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  enb_,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(1<<SEL_W)-1:0] out,
  output logic                  busy,
  output logic                  wrap
);

  localparam int OUT_W = 1 << SEL_W;

  state_t             state, state_n;
  logic [SEL_W-1:0]   idx, idx_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic               busy_n, wrap_n, line_en;
  logic [OUT_W-1:0]   out_n;

  // out_n is decoded from the next index so out changes on the same edge as the state
  dec_onehot #(.SEL_W(SEL_W)) u_dec (
    .en  (line_en),
    .sel (idx_n),
    .out (out_n)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    dwell_n = dwell_q;
    busy_n  = 1'b0;
    wrap_n  = 1'b0;
    line_en = 1'b0;
    if (enb_) begin
      state_n = ST_IDLE;
    end else if (load) begin
      idx_n   = sel;
      cnt_n   = dwell;
      dwell_n = dwell;
      line_en = 1'b1;
      case (mode)
        MODE_PULSE: state_n = ST_PULSE;
        MODE_SCAN: begin
          state_n = ST_SCAN;
          busy_n  = 1'b1;
        end
        default:    state_n = ST_HOLD;
      endcase
    end else begin
      case (state)
        ST_HOLD:  line_en = 1'b1;
        ST_PULSE: state_n = ST_IDLE;
        ST_SCAN: begin
          busy_n  = 1'b1;
          line_en = 1'b1;
          if (cnt == '0) begin
            cnt_n  = dwell_q;
            idx_n  = idx + 1'b1;
            wrap_n = &idx;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state   <= ST_IDLE;
      idx     <= '0;
      cnt     <= '0;
      dwell_q <= '0;
      out     <= '0;
      busy    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      dwell_q <= dwell_n;
      out     <= out_n;
      busy    <= busy_n;
      wrap    <= wrap_n;
    end
  end

endmodule

// File: tb/tb_dec_seq.sv
// tb/tb_dec_seq.sv - randomized and directed self-checking bench for dec_seq
module tb_dec_seq;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       enb_ = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [2:0] sel = '0;
  logic [3:0] dwell = '0;
  logic [7:0] out;
  logic       busy, wrap;

  logic [0:0]  sel1 = '0;
  logic [1:0]  sel2 = '0;
  logic [3:0]  sel4 = '0;
  logic [1:0]  out1;
  logic [3:0]  out2;
  logic [15:0] out4;
  logic        busy1, wrap1, busy2, wrap2, busy4, wrap4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dec_seq #(.SEL_W(3), .DWELL_W(4)) dut (
    .clk(clk), .rst_(rst_), .enb_(enb_), .mode(mode), .load(load),
    .sel(sel), .dwell(dwell), .out(out), .busy(busy), .wrap(wrap));

  dec_seq #(.SEL_W(1), .DWELL_W(4)) dut1 (
    .clk(clk), .rst_(rst_), .enb_(enb_), .mode(mode), .load(load),
    .sel(sel1), .dwell(dwell), .out(out1), .busy(busy1), .wrap(wrap1));

  dec_seq #(.SEL_W(2), .DWELL_W(4)) dut2 (
    .clk(clk), .rst_(rst_), .enb_(enb_), .mode(mode), .load(load),
    .sel(sel2), .dwell(dwell), .out(out2), .busy(busy2), .wrap(wrap2));

  dec_seq #(.SEL_W(4), .DWELL_W(4)) dut4 (
    .clk(clk), .rst_(rst_), .enb_(enb_), .mode(mode), .load(load),
    .sel(sel4), .dwell(dwell), .out(out4), .busy(busy4), .wrap(wrap4));

  // Reference: the last accepted command and the number of cycles its output has been visible
  bit       m_act = 1'b0;
  bit [1:0] m_mode;
  int       m_sel, m_dwell, m_t;

  always @(posedge clk or negedge rst_) begin
    if (!rst_) m_act = 1'b0;
    else if (enb_) m_act = 1'b0;
    else if (load) begin
      m_act = 1'b1; m_mode = mode; m_sel = sel; m_dwell = dwell; m_t = 1;
    end else if (m_act) m_t++;
  end

  function automatic int m_line();
    return (m_sel + (m_t - 1) / (m_dwell + 1)) % 8;
  endfunction

  function automatic logic [7:0] m_out();
    logic [7:0] one = 8'd1;
    if (!m_act) return 8'd0;
    case (m_mode)
      2'b01:   return (m_t == 1) ? (one << m_sel) : 8'd0;
      2'b10:   return one << m_line();
      default: return one << m_sel;
    endcase
  endfunction

  function automatic logic m_busy();
    return m_act && m_mode == 2'b10;
  endfunction

  function automatic logic m_wrap();
    int k = m_t - 1;
    return m_busy() && k > 0 && (k % (m_dwell + 1)) == 0 && m_line() == 0;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if (out !== 8'd0 || busy !== 1'b0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset out=%b busy=%b wrap=%b required 00000000 0 0", out, busy, wrap);
    end
    rst_ = 1'b1;
  endtask

  task automatic test_enable();
    enb_ = 1'b1; load = 1'b1; mode = 2'b00; sel = 3'd5;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (out !== 8'd0) begin
        n_fail++;
        $display("FAIL enb_high_load out=%b required 00000000", out);
      end
    end
    load = 1'b0; enb_ = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (out !== 8'd0) begin
      n_fail++;
      $display("FAIL enb_fall_wait out=%b required 00000000", out);
    end
  endtask

  task automatic test_level();
    mode = 2'b00; sel = 3'd3; load = 1'b1;
    @(negedge clk);
    load = 1'b0; sel = 3'd0; mode = 2'b10;
    for (int c = 0; c < 20; c++) begin
      n_tests++;
      if (out !== 8'b00001000 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL level_hold cyc=%0d out=%b busy=%b required 00001000 0", c, out, busy);
      end
      @(negedge clk);
    end
    mode = 2'b00; sel = 3'd6; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n_tests++;
    if (out !== 8'b01000000) begin
      n_fail++;
      $display("FAIL level_reload out=%b required 01000000", out);
    end
  endtask

  task automatic test_pulse();
    mode = 2'b01; sel = 3'd7; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n_tests++;
    if (out !== 8'b10000000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_on out=%b busy=%b required 10000000 0", out, busy);
    end
    @(negedge clk);
    n_tests++;
    if (out !== 8'd0) begin
      n_fail++;
      $display("FAIL pulse_off out=%b required 00000000", out);
    end
    sel = 3'd1; load = 1'b1;
    @(negedge clk);
    sel = 3'd2;
    n_tests++;
    if (out !== 8'b00000010) begin
      n_fail++;
      $display("FAIL back_to_back_1 out=%b required 00000010", out);
    end
    @(negedge clk);
    load = 1'b0;
    n_tests++;
    if (out !== 8'b00000100) begin
      n_fail++;
      $display("FAIL back_to_back_2 out=%b required 00000100", out);
    end
    @(negedge clk);
    n_tests++;
    if (out !== 8'd0) begin
      n_fail++;
      $display("FAIL back_to_back_off out=%b required 00000000", out);
    end
  endtask

  task automatic test_scan();
    int wraps = 0;
    logic [7:0] e;
    mode = 2'b10; sel = 3'd6; dwell = 4'd2; load = 1'b1;
    @(negedge clk);
    load = 1'b0; sel = 3'd1; dwell = 4'd9;
    for (int c = 0; c < 30; c++) begin
      e = 8'd1 << ((6 + c / 3) % 8);
      n_tests++;
      if (out !== e || busy !== 1'b1 || wrap !== (c == 6)) begin
        n_fail++;
        $display("FAIL scan cyc=%0d out=%b busy=%b wrap=%b required %b 1 %b", c, out, busy, wrap, e, c == 6);
      end
      if (wrap === 1'b1) wraps++;
      @(negedge clk);
    end
    n_tests++;
    if (wraps != 1) begin
      n_fail++;
      $display("FAIL scan_wrap_count got=%0d required 1", wraps);
    end
  endtask

  task automatic test_scan_edges();
    logic [7:0] e;
    mode = 2'b10; sel = 3'd0; dwell = 4'd0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int c = 0; c < 10; c++) begin
      e = 8'd1 << (c % 8);
      n_tests++;
      if (out !== e || wrap !== (c == 8)) begin
        n_fail++;
        $display("FAIL scan_dwell0 cyc=%0d out=%b wrap=%b required %b %b", c, out, wrap, e, c == 8);
      end
      @(negedge clk);
    end
    enb_ = 1'b1;
    @(negedge clk);
    enb_ = 1'b0;
    n_tests++;
    if (out !== 8'd0 || busy !== 1'b0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_enb_high out=%b busy=%b wrap=%b required 00000000 0 0", out, busy, wrap);
    end
    mode = 2'b10; sel = 3'd2; dwell = 4'd3; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    mode = 2'b00; sel = 3'd4; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n_tests++;
    if (out !== 8'b00010000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_to_level out=%b busy=%b required 00010000 0", out, busy);
    end
  endtask

  task automatic test_async_reset();
    mode = 2'b10; sel = 3'd5; dwell = 4'd1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_ = 1'b0;
    #1;
    n_tests++;
    if (out !== 8'd0 || busy !== 1'b0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset out=%b busy=%b wrap=%b required 00000000 0 0", out, busy, wrap);
    end
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic test_sweep();
    logic [1:0]  o1 = 2'd1;
    logic [3:0]  o2 = 4'd1;
    logic [15:0] o4 = 16'd1;
    mode = 2'b00;
    for (int s = 0; s < 16; s++) begin
      sel4 = 4'(s); sel2 = 2'(s % 4); sel1 = 1'(s % 2); load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      n_tests++;
      if (out1 !== (o1 << (s % 2)) || out2 !== (o2 << (s % 4)) || out4 !== (o4 << s)) begin
        n_fail++;
        $display("FAIL sweep sel=%0d out1=%b out2=%b out4=%b", s, out1, out2, out4);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      enb_  = ($urandom_range(0, 14) == 0);
      load  = ($urandom_range(0, 5) == 0);
      mode  = 2'($urandom_range(0, 3));
      sel   = 3'($urandom);
      dwell = 4'($urandom_range(0, 3));
      sel1  = 1'($urandom); sel2 = 2'($urandom); sel4 = 4'($urandom);
      @(negedge clk);
      n_tests++;
      if (out !== m_out() || busy !== m_busy() || wrap !== m_wrap()) begin
        n_fail++;
        $display("FAIL random cyc=%0d out=%b busy=%b wrap=%b required %b %b %b",
                 c, out, busy, wrap, m_out(), m_busy(), m_wrap());
      end
      n_tests++;
      if ($countones(out1) > 1 || $countones(out2) > 1 || $countones(out4) > 1) begin
        n_fail++;
        $display("FAIL onehot cyc=%0d out1=%b out2=%b out4=%b required at most one bit", c, out1, out2, out4);
      end
    end
    enb_ = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_enable();
    test_level();
    test_pulse();
    test_scan();
    test_scan_edges();
    test_async_reset();
    test_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
